// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter.
// Holds the word width inherited from the instruction length, the default
// wait-state count, the wait counter width and the FSM/owner encodings.
package mem_arbiter_pkg;

   localparam int INSTRUCTION_LEN   = 32;
   localparam int MEM_ACCESS_CYCLES = 2;
   localparam int CNT_W             = 4;   // enough for 1..15 wait states

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_DONE = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } arb_owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that times the wait states of one memory access.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   load      - load load_val (has priority over en)
//   en        - decrement by one; holds at zero
//   load_val  - value loaded on load
//   count     - current count
//   zero      - count == 0
module arb_wait_counter
   import mem_arbiter_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             zero
);

   assign zero = (count == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && !zero)
         count <= count - CNT_W'(1);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the pipelined core. Shares one memory
// between the instruction fetch port (read-only) and the data port
// (read/write), data having strict priority. Each access spends
// ACCESS_CYCLES cycles in BUSY and one cycle in DONE, where a one-cycle
// ack is issued together with the registered read word.
// Ports:
//   clk, rst                 - clock, asynchronous active-low reset
//   i_req/i_addr             - fetch request and byte address
//   i_rdata/i_ack            - fetched word and completion pulse
//   d_req/d_we/d_addr/d_wdata- data request, direction, address, store data
//   d_rdata/d_ack            - loaded word (0 for stores) and completion pulse
//   mem_addr/mem_wdata       - memory address and write data
//   mem_read/mem_write       - memory enables
//   mem_rdata                - combinational memory read data
//   busy                     - high while an access is in flight (BUSY/DONE)
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ACCESS_CYCLES = MEM_ACCESS_CYCLES,
   parameter int DATA_W        = INSTRUCTION_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [DATA_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [DATA_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   arb_state_t        state, state_nxt;
   arb_owner_t        owner;
   logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
   logic              we_q;

   logic              grant_d, grant_i, cnt_load, cnt_en, capture;
   logic [CNT_W-1:0]  cnt;
   logic              cnt_zero;

   arb_wait_counter u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (CNT_W'(ACCESS_CYCLES - 1)),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_i   = 1'b0;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      capture   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (d_req) begin
               grant_d   = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = ARB_BUSY;
            end else if (i_req) begin
               grant_i   = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            cnt_en = 1'b1;
            if (cnt_zero) begin
               capture   = !we_q;
               state_nxt = ARB_DONE;
            end
         end
         // DONE never samples requests: the requester sees ack this cycle
         // and may only change its operands afterwards.
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ARB_IDLE;
         owner   <= OWNER_FETCH;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (grant_d) begin
            owner   <= OWNER_DATA;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            we_q    <= d_we;
         end else if (grant_i) begin
            owner   <= OWNER_FETCH;
            addr_q  <= i_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
         end
         if (capture)
            rdata_q <= mem_rdata;
      end
   end

   // Memory side is driven purely from registered state, so an async reset
   // mid-access kills mem_write in the same cycle.
   logic in_busy, in_done;
   assign in_busy = (state == ARB_BUSY);
   assign in_done = (state == ARB_DONE);

   assign busy      = in_busy || in_done;
   assign mem_addr  = in_busy ? addr_q  : '0;
   assign mem_wdata = in_busy ? wdata_q : '0;
   assign mem_read  = in_busy && !we_q;
   // Only the last wait cycle writes, so a store produces a single write edge.
   assign mem_write = in_busy && we_q && cnt_zero;

   assign i_ack   = in_done && (owner == OWNER_FETCH);
   assign d_ack   = in_done && (owner == OWNER_DATA);
   assign i_rdata = i_ack ? rdata_q : '0;
   assign d_rdata = (d_ack && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (ACCESS_CYCLES=2): per-cycle vector table
// against a small word memory model, plus a hand-written mid-store reset.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        i_ack, d_ack, mem_read, mem_write, busy;

   always #5 clk = ~clk;

   mem_arbiter #(.ACCESS_CYCLES(2), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Word memory model indexed by byte address bits [11:2].
   bit [31:0] mem [0:1023];
   logic      preload;
   always @(posedge clk) begin
      if (preload) begin
         mem[1] <= 32'hE3A01A01;   // byte address 4
         mem[2] <= 32'h12345678;   // byte address 8
      end else if (mem_write) begin
         mem[mem_addr[11:2]] <= mem_wdata;
      end
   end
   assign mem_rdata = mem[mem_addr[11:2]];

   typedef struct {
      bit          rst, ir;
      logic [31:0] ia;
      bit          dr, dw;
      logic [31:0] da, dd;
      bit          e_iack, e_dack, e_rd, e_wr, e_busy;
      logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   passed = 0;

   task automatic add(bit r, bit ir, logic [31:0] ia, bit dr, bit dw,
                      logic [31:0] da, logic [31:0] dd,
                      bit ik, bit dk, bit rd, bit wr, bit by,
                      logic [31:0] ma, logic [31:0] mw,
                      logic [31:0] ird, logic [31:0] drd);
      vec_t v;
      v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
      v.e_iack = ik; v.e_dack = dk; v.e_rd = rd; v.e_wr = wr; v.e_busy = by;
      v.e_maddr = ma; v.e_mwdata = mw; v.e_irdata = ird; v.e_drdata = drd;
      vecs.push_back(v);
   endtask

   task automatic chk(string name, logic [132:0] act, logic [132:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic logic [132:0] outs();
      return {i_ack, d_ack, mem_read, mem_write, busy,
              mem_addr, mem_wdata, i_rdata, d_rdata};
   endfunction

   initial begin
      rst = 1'b0; preload = 1'b1;
      i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

      // reset held with a pending store, then release -> store granted
      add(0,0,0, 1,1,16,32'hAA, 0,0,0,0,0, 0,0,0,0);
      add(0,0,0, 1,1,16,32'hAA, 0,0,0,0,0, 0,0,0,0);
      add(1,0,0, 1,1,16,32'hAA, 0,0,0,0,0, 0,0,0,0);
      add(1,0,0, 1,1,16,32'hAA, 0,0,0,0,1, 16,32'hAA,0,0);
      add(1,0,0, 1,1,16,32'hAA, 0,0,0,1,1, 16,32'hAA,0,0);
      add(1,0,0, 1,1,16,32'hAA, 0,1,0,0,1, 0,0,0,0);
      add(1,0,0, 0,0,0,0,       0,0,0,0,0, 0,0,0,0);
      // fetch from 4
      add(1,1,4, 0,0,0,0, 0,0,0,0,0, 0,0,0,0);
      add(1,1,4, 0,0,0,0, 0,0,1,0,1, 4,0,0,0);
      add(1,1,4, 0,0,0,0, 0,0,1,0,1, 4,0,0,0);
      add(1,1,4, 0,0,0,0, 1,0,0,0,1, 0,0,32'hE3A01A01,0);
      add(1,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0);
      // store 0xC0000000 to 1024, then load it back
      add(1,0,0, 1,1,1024,32'hC0000000, 0,0,0,0,0, 0,0,0,0);
      add(1,0,0, 1,1,1024,32'hC0000000, 0,0,0,0,1, 1024,32'hC0000000,0,0);
      add(1,0,0, 1,1,1024,32'hC0000000, 0,0,0,1,1, 1024,32'hC0000000,0,0);
      add(1,0,0, 1,1,1024,32'hC0000000, 0,1,0,0,1, 0,0,0,0);
      add(1,0,0, 1,0,1024,0, 0,0,0,0,0, 0,0,0,0);
      add(1,0,0, 1,0,1024,0, 0,0,1,0,1, 1024,0,0,0);
      add(1,0,0, 1,0,1024,0, 0,0,1,0,1, 1024,0,0,0);
      add(1,0,0, 1,0,1024,0, 0,1,0,0,1, 0,0,0,32'hC0000000);
      add(1,0,0, 0,0,0,0,    0,0,0,0,0, 0,0,0,0);
      // simultaneous: data (load 8) first, fetch (4) after
      add(1,1,4, 1,0,8,0, 0,0,0,0,0, 0,0,0,0);
      add(1,1,4, 1,0,8,0, 0,0,1,0,1, 8,0,0,0);
      add(1,1,4, 1,0,8,0, 0,0,1,0,1, 8,0,0,0);
      add(1,1,4, 1,0,8,0, 0,1,0,0,1, 0,0,0,32'h12345678);
      add(1,1,4, 0,0,0,0, 0,0,0,0,0, 0,0,0,0);
      add(1,1,4, 0,0,0,0, 0,0,1,0,1, 4,0,0,0);
      add(1,1,4, 0,0,0,0, 0,0,1,0,1, 4,0,0,0);
      add(1,1,4, 0,0,0,0, 1,0,0,0,1, 0,0,32'hE3A01A01,0);
      add(1,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0);
      // operand change during BUSY is ignored
      add(1,0,0, 1,0,1024,0, 0,0,0,0,0, 0,0,0,0);
      add(1,0,0, 1,0,8,0,    0,0,1,0,1, 1024,0,0,0);
      add(1,0,0, 1,0,8,0,    0,0,1,0,1, 1024,0,0,0);
      add(1,0,0, 1,0,8,0,    0,1,0,0,1, 0,0,0,32'hC0000000);
      add(1,0,0, 0,0,0,0,    0,0,0,0,0, 0,0,0,0);

      @(posedge clk); #1 preload = 1'b0;

      foreach (vecs[k]) begin
         rst = vecs[k].rst; i_req = vecs[k].ir; i_addr = vecs[k].ia;
         d_req = vecs[k].dr; d_we = vecs[k].dw; d_addr = vecs[k].da;
         d_wdata = vecs[k].dd;
         @(negedge clk);
         chk($sformatf("vec%0d", k), outs(),
             {vecs[k].e_iack, vecs[k].e_dack, vecs[k].e_rd, vecs[k].e_wr,
              vecs[k].e_busy, vecs[k].e_maddr, vecs[k].e_mwdata,
              vecs[k].e_irdata, vecs[k].e_drdata});
         @(posedge clk); #1;
      end

      chk("store16_in_mem", 133'(mem[4]), 133'(32'hAA));

      // reset in the write cycle of a store to 32
      d_req = 1; d_we = 1; d_addr = 32; d_wdata = 32'h55;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_write_before", 133'(mem_write), 133'(1));
      rst = 0; d_req = 0; d_we = 0;
      #1;
      chk("midrst_write_drop", 133'({mem_write, busy, mem_addr}), 133'(0));
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_noack%0d", c), 133'({d_ack, i_ack, busy}), 133'(0));
      end
      #1 rst = 1;
      @(negedge clk);
      chk("midrst_mem_untouched", 133'(mem[8]), 133'(0));
      chk("midrst_idle", 133'({busy, mem_read, mem_write}), 133'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
